// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared state encoding, defaults and window helper for the clock period monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } clk_mon_state_e;

    localparam int unsigned EXP_HALF_DEFAULT   = 100000;
    localparam int unsigned TOL_DEFAULT        = 16;
    localparam int unsigned LOCK_COUNT_DEFAULT = 4;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned ERR_W = 8;

    // Bounds are carried at 34 bits so EXP_HALF+TOL+1 cannot overflow.
    function automatic logic in_window(input logic [33:0] val,
                                       input logic [33:0] lo,
                                       input logic [33:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer plus edge-detect register for an asynchronous input
//
// Ports:
//   clk_i   : sampling clock, rising edge
//   rst_ni  : asynchronous active-low reset, clears all three flops
//   async_i : asynchronous input level
//   edge_o  : high for one clk_i cycle after either polarity change of async_i
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Only stages 2 and 3 are compared; stage 1 may still be metastable.
    assign edge_o = sync2_q ^ sync3_q;

endmodule

// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - measures half-periods of an asynchronous clock and tracks lock/fault
//
// Ports:
//   in_clk       : reference clock, all logic on its rising edge
//   rst_n        : asynchronous active-low reset
//   mon_clk      : monitored clock, asynchronous to in_clk
//   clear        : synchronous restart to IDLE, zeroes counters and half_period
//   half_period  : last measured half-period in in_clk cycles
//   sample_valid : one-cycle pulse when half_period updates
//   locked       : state is LOCKED
//   fault        : state is FAULT (sticky until clear/reset)
//   err_cnt      : saturating count of out-of-range half-periods
module clock_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned EXP_HALF   = EXP_HALF_DEFAULT,
    parameter int unsigned TOL        = TOL_DEFAULT,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic                 in_clk,
    input  logic                 rst_n,
    input  logic                 mon_clk,
    input  logic                 clear,
    output logic [CNT_W-1:0]     half_period,
    output logic                 sample_valid,
    output logic                 locked,
    output logic                 fault,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam logic [33:0] HI_B    = 34'(EXP_HALF) + 34'(TOL);
    localparam logic [33:0] LO_B    = (EXP_HALF > TOL) ? 34'(EXP_HALF - TOL) : 34'd0;
    localparam logic [33:0] STALL_B = HI_B + 34'd1;
    localparam int unsigned GOOD_W  = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    clk_mon_state_e     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic               sv_q, sv_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic               mon_edge;
    logic               interval_ok;
    logic               stalled;
    logic [ERR_W-1:0]   err_inc;
    logic [GOOD_W-1:0]  good_inc;

    sync_edge_detect u_sync_edge (
        .clk_i   (in_clk),
        .rst_ni  (rst_n),
        .async_i (mon_clk),
        .edge_o  (mon_edge)
    );

    // On an edge cycle cnt_q holds the length of the interval just closed.
    assign interval_ok = in_window({2'b00, cnt_q}, LO_B, HI_B);
    assign stalled     = ({2'b00, cnt_q} >= STALL_B);
    assign err_inc     = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
    assign good_inc    = good_q + GOOD_W'(1);

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        half_d  = half_q;
        sv_d    = 1'b0;
        err_d   = err_q;

        if (mon_edge) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (clear) begin
            // Clear outranks a coincident edge, so no sample is produced.
            state_d = ST_IDLE;
            cnt_d   = '0;
            good_d  = '0;
            half_d  = '0;
            err_d   = '0;
        end else begin
            if (mon_edge && (state_q != ST_IDLE)) begin
                half_d = cnt_q;
                sv_d   = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // First interval has no known start, so it is discarded.
                    if (mon_edge) begin
                        state_d = ST_MEASURE;
                        good_d  = '0;
                    end
                end
                ST_MEASURE: begin
                    if (mon_edge) begin
                        if (interval_ok) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_W'(LOCK_COUNT)) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            good_d = '0;
                            err_d  = err_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (mon_edge) begin
                        if (!interval_ok) begin
                            state_d = ST_FAULT;
                            err_d   = err_inc;
                        end
                    end else if (stalled) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            good_q <= '0;
        end else begin
            good_q <= good_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= '0;
            sv_q   <= 1'b0;
        end else begin
            half_q <= half_d;
            sv_q   <= sv_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign half_period  = half_q;
    assign sample_valid = sv_q;
    assign locked       = (state_q == ST_LOCKED);
    assign fault        = (state_q == ST_FAULT);
    assign err_cnt      = err_q;

endmodule
